// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit, receive and buffering blocks.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int UART_FIFO_ADDR_W = 4;

   // Line levels: the serial line idles high and a frame opens with a low start bit.
   localparam logic B_IDLE  = 1'b1;
   localparam logic B_START = 1'b0;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array for the UART buffers.
// Write is synchronous and read is asynchronous, so the head entry is visible in the same cycle.
module uart_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage is deliberately not reset; the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with status, sticky overrun and level irq.
// A written byte is visible one clock later; a write into a full FIFO without a pop is dropped and flagged.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_stb_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_stb_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [ADDR_W:0]   count_o,
   output logic              ovr_o,
   input  logic              ovr_clr_i,
   input  logic [ADDR_W:0]   thresh_i,
   output logic              irq_o
);

   localparam int CW    = ADDR_W + 1;
   localparam int DEPTH = 2**ADDR_W;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic [CW-1:0]     thresh_eff;
   logic [DATA_W-1:0] mem_rd_data;
   logic              empty;
   logic              full;
   logic              wr_acc;
   logic              rd_acc;
   logic              ovr;
   logic              ovr_set;
   logic              irq;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop in the same cycle frees the slot, so a write into a full FIFO is only dropped without one.
   assign rd_acc  = rd_stb_i && !empty;
   assign wr_acc  = wr_stb_i && (!full || rd_acc);
   assign ovr_set = wr_stb_i && full && !rd_acc;

   assign thresh_eff = (thresh_i == '0) ? CW'(1) : thresh_i;

   always_comb begin
      count_next = count;
      if (wr_acc && !rd_acc) begin
         count_next = count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr    <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         count <= count_next;
         ovr   <= ovr_set || (ovr && !ovr_clr_i);
         irq   <= (count_next >= thresh_eff);
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i     (clk_i),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr),
      .wr_data_i (wr_data_i),
      .rd_addr_i (rd_ptr),
      .rd_data_o (mem_rd_data)
   );

   assign rd_data_o = empty ? '0 : mem_rd_data;
   assign empty_o   = empty;
   assign full_o    = full;
   assign count_o   = count;
   assign ovr_o     = ovr;
   assign irq_o     = irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: FWFT order, fill/overrun/wrap, coincident events, irq threshold, async reset.
module tb_uart_rx_fifo;

   logic       clk_i;
   logic       rst_n_i;
   logic       wr_stb_i;
   logic [7:0] wr_data_i;
   logic       rd_stb_i;
   logic [7:0] rd_data_o;
   logic       empty_o;
   logic       full_o;
   logic [4:0] count_o;
   logic       ovr_o;
   logic       ovr_clr_i;
   logic [4:0] thresh_i;
   logic       irq_o;

   int vec_cnt;
   int err_cnt;

   uart_rx_fifo dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_stb_i  (wr_stb_i),
      .wr_data_i (wr_data_i),
      .rd_stb_i  (rd_stb_i),
      .rd_data_o (rd_data_o),
      .empty_o   (empty_o),
      .full_o    (full_o),
      .count_o   (count_o),
      .ovr_o     (ovr_o),
      .ovr_clr_i (ovr_clr_i),
      .thresh_i  (thresh_i),
      .irq_o     (irq_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge and outputs are sampled there too.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_stb_i  = 1'b1;
      wr_data_i = d;
      step();
      wr_stb_i  = 1'b0;
   endtask

   task automatic pop();
      rd_stb_i = 1'b1;
      step();
      rd_stb_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_empty"}, 32'(empty_o),   32'd1);
      check({pfx, "_full"},  32'(full_o),    32'd0);
      check({pfx, "_count"}, 32'(count_o),   32'd0);
      check({pfx, "_ovr"},   32'(ovr_o),     32'd0);
      check({pfx, "_irq"},   32'(irq_o),     32'd0);
      check({pfx, "_rdata"}, 32'(rd_data_o), 32'h00);
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      rst_n_i   = 1'b0;
      wr_stb_i  = 1'b0;
      wr_data_i = 8'h00;
      rd_stb_i  = 1'b0;
      ovr_clr_i = 1'b0;
      thresh_i  = 5'd16;
      #12;
      rst_n_i = 1'b1;
      repeat (5) step();
      check_reset_outputs("reset");

      // FWFT: first byte visible one clock after its write
      wr_stb_i = 1'b1; wr_data_i = 8'hA5;
      step();
      wr_data_i = 8'h3C;
      check("fwft_first", 32'(rd_data_o), 32'hA5);
      check("fwft_nempty", 32'(empty_o), 32'd0);
      step();
      wr_stb_i = 1'b0;
      check("fwft_count2", 32'(count_o), 32'd2);
      pop();
      check("fwft_second", 32'(rd_data_o), 32'h3C);
      pop();
      check("fwft_empty", 32'(empty_o), 32'd1);
      check("fwft_rd_zero", 32'(rd_data_o), 32'h00);

      // Pop on empty is ignored
      pop();
      check("pop_empty_count", 32'(count_o), 32'd0);

      // Fill, overrun, wrap
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill_full", 32'(full_o), 32'd1);
      check("fill_count", 32'(count_o), 32'd16);
      check("fill_irq", 32'(irq_o), 32'd1);
      push(8'hEE);
      check("ovr_set", 32'(ovr_o), 32'd1);
      check("ovr_count", 32'(count_o), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain_%0d", i), 32'(rd_data_o), 32'(i));
         pop();
      end
      check("drain_empty", 32'(empty_o), 32'd1);
      check("drain_irq", 32'(irq_o), 32'd0);
      check("ovr_hold", 32'(ovr_o), 32'd1);
      ovr_clr_i = 1'b1;
      step();
      ovr_clr_i = 1'b0;
      check("ovr_clr", 32'(ovr_o), 32'd0);

      // Write and pop together while full
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      wr_stb_i = 1'b1; wr_data_i = 8'h77; rd_stb_i = 1'b1;
      step();
      wr_stb_i = 1'b0; rd_stb_i = 1'b0;
      check("fullrw_count", 32'(count_o), 32'd16);
      check("fullrw_ovr", 32'(ovr_o), 32'd0);
      check("fullrw_head", 32'(rd_data_o), 32'h11);
      for (int i = 1; i < 16; i++) begin
         check($sformatf("fullrw_drain_%0d", i), 32'(rd_data_o), 32'(8'h10 + i));
         pop();
      end
      check("fullrw_last", 32'(rd_data_o), 32'h77);
      pop();
      check("fullrw_empty", 32'(empty_o), 32'd1);

      // Write and pop together while empty
      wr_stb_i = 1'b1; wr_data_i = 8'h55; rd_stb_i = 1'b1;
      step();
      wr_stb_i = 1'b0; rd_stb_i = 1'b0;
      check("emptyrw_count", 32'(count_o), 32'd1);
      check("emptyrw_data", 32'(rd_data_o), 32'h55);
      pop();

      // Clear coincident with a new overrun: set wins
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      wr_stb_i = 1'b1; wr_data_i = 8'hEE; ovr_clr_i = 1'b1;
      step();
      wr_stb_i = 1'b0; ovr_clr_i = 1'b0;
      check("ovr_set_wins", 32'(ovr_o), 32'd1);
      ovr_clr_i = 1'b1;
      step();
      ovr_clr_i = 1'b0;
      check("ovr_clr2", 32'(ovr_o), 32'd0);
      for (int i = 0; i < 16; i++) pop();
      check("drain2_count", 32'(count_o), 32'd0);

      // Threshold interrupt
      thresh_i = 5'd4;
      push(8'h01);
      check("irq_w1", 32'(irq_o), 32'd0);
      push(8'h02);
      check("irq_w2", 32'(irq_o), 32'd0);
      push(8'h03);
      check("irq_w3", 32'(irq_o), 32'd0);
      push(8'h04);
      check("irq_w4", 32'(irq_o), 32'd1);
      pop();
      check("irq_pop", 32'(irq_o), 32'd0);
      for (int i = 0; i < 3; i++) pop();
      check("irq_empty", 32'(empty_o), 32'd1);
      thresh_i = 5'd0;
      step();
      check("thr0_idle", 32'(irq_o), 32'd0);
      push(8'h09);
      check("thr0_irq", 32'(irq_o), 32'd1);

      // Async reset between edges with five entries held
      for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
      check("pre_rst_count", 32'(count_o), 32'd5);
      #2;
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #1;
      rst_n_i = 1'b1;
      step();
      push(8'hC3);
      check("post_rst_data", 32'(rd_data_o), 32'hC3);
      check("post_rst_count", 32'(count_o), 32'd1);
      pop();
      check("post_rst_empty", 32'(empty_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver in the UART controller.
- Captures each byte presented on the receiver's 8-bit data output when its one-cycle "done" strobe fires.
- Holds bytes in a circular FIFO and presents them to the CPU-side register interface first-word-fall-through.
- Provides empty/full/level status, a sticky overrun flag and a level-threshold interrupt request.

Parameters:
- DATA_W, 8, byte width; matches the receiver output.
- ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W = 16 entries.

Ports:
- clk_i  in  1  CPU clock; single clock domain.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_stb_i  in  1  byte-received strobe; connect to receiver done strobe; one cycle wide.
- wr_data_i  in  DATA_W  received byte; valid in the cycle wr_stb_i is high.
- rd_stb_i  in  1  CPU pop strobe; one cycle per byte read.
- rd_data_o  out  DATA_W  head-of-queue byte (FWFT).
- empty_o  out  1  FIFO holds 0 entries.
- full_o  out  1  FIFO holds 2**ADDR_W entries.
- count_o  out  ADDR_W+1  current occupancy, 0..16.
- ovr_o  out  1  sticky overrun flag.
- ovr_clr_i  in  1  clears ovr_o; one-cycle strobe.
- thresh_i  in  ADDR_W+1  interrupt level threshold; 0 is treated as 1.
- irq_o  out  1  registered level interrupt.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - wr_ptr, rd_ptr and count = 0.
  - empty_o = 1, full_o = 0, ovr_o = 0, irq_o = 0, rd_data_o = 8'h00.
  - Memory contents are not reset.
- Storage:
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap modulo depth (15 -> 0).
  - count is a separate ADDR_W+1 bit register; empty_o = (count == 0), full_o = (count == 16). Both are combinational from count.
- Write: when wr_stb_i = 1 and the write is accepted, mem[wr_ptr] <= wr_data_i and wr_ptr++ at the clock edge.
- Read:
  - rd_data_o = mem[rd_ptr] combinationally when not empty; 8'h00 when empty.
  - rd_stb_i = 1 while not empty: rd_ptr++ at the edge, so the next byte is visible the following cycle.
  - rd_stb_i while empty is ignored: no pointer or count change and no error.
- Acceptance rules per cycle:
  - Write alone, not full: accept, count+1.
  - Write alone, full: byte dropped, memory and pointers unchanged, ovr_o <= 1.
  - Read alone, not empty: pop, count-1.
  - Write and read together, not empty (including full): both accepted, count unchanged, no overrun.
  - Write and read together while empty: write accepted, read ignored, count becomes 1. Newly written data is visible on rd_data_o only from the next cycle.
- Overrun flag:
  - ovr_o is sticky until ovr_clr_i.
  - If ovr_clr_i and a new overrun occur in the same cycle, set wins.
- Interrupt:
  - irq_o <= (count_next >= max(thresh_i, 1)), registered, so it is valid in the cycle after the count changes.
  - irq_o is level, not pulse; it deasserts once reads bring the level below the threshold.
- Latency: write to visible on rd_data_o / empty_o deasserted is 1 clock.
- Reset mid-operation: all state returns to reset values immediately; stored bytes are discarded.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - UART_FIFO_ADDR_W = 4.
  - the B_IDLE/B_START bit constants shared with the TX/RX blocks.
- One natural sub-module: uart_fifo_mem.
  - Simple dual-port register array: synchronous write, asynchronous read, parameterised DATA_W/ADDR_W.
  - Pointers, count, flags and irq stay in uart_rx_fifo.

Test Plan:
- Reset: then idle 5 cycles -> empty_o=1, full_o=0, count_o=0, ovr_o=0, irq_o=0, rd_data_o=8'h00.
- Basic FWFT: write 8'hA5, next cycle 8'h3C -> rd_data_o=8'hA5 one cycle after the first write. Then pop twice -> 8'h3C, then empty_o=1 and rd_data_o=8'h00.
- Fill, overrun and wrap:
  - Write 16 bytes 8'h00..8'h0F -> full_o=1, count_o=16.
  - 17th write 8'hEE -> dropped, ovr_o=1, count_o stays 16.
  - Pop all 16 -> 8'h00..8'h0F in order with no 8'hEE; pointers wrap.
  - ovr_clr_i -> ovr_o=0.
- Simultaneous events:
  - While full, write and pop in the same cycle -> count_o stays 16, ovr_o stays 0, new byte appears last.
  - While empty, write and pop in the same cycle -> count_o=1.
  - ovr_clr_i coincident with an overrun -> ovr_o=1.
- Threshold irq:
  - thresh_i=4: writes 1..3 -> irq_o=0; 4th write -> irq_o=1 one cycle later.
  - One pop -> irq_o=0 the next cycle.
  - thresh_i=0 -> irq_o=1 after the first byte.
- Async reset mid-stream: with count_o=5, pulse rst_n_i low between edges -> all outputs return to reset values immediately, without waiting for a clock. The next write is read back as the sole entry.
